// File: rtl/train_detect.sv
// train_detect: axle-counting track-section detector with debounced sensors,
// occupancy counter, hold timer and a ctl_* register target.
// Optional feature: define TRAIN_DET_TOTAL_EN to build the 32-bit entry total
// counter at offset 4.
module train_detect #(
  parameter int unsigned DEB_W  = 8,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned HOLD_W = 16
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        sens_in,
  input  logic        sens_out,
  input  logic        ctl_wr,
  input  logic        ctl_rd,
  input  logic [2:0]  ctl_addr,
  input  logic [31:0] ctl_wrdata,
  output logic [31:0] ctl_rddata,
  output logic        train,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OCC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] OCC_MAX = '1;

  logic [1:0]        sync1, sync2, filt, filt_q;
  logic [DEB_W-1:0]  deb_cnt [2];
  logic              ev_in, ev_out;

  logic              enable;
  logic [DEB_W-1:0]  deb_len;
  logic [HOLD_W-1:0] hold_len;
  logic              wr_ctrl, clr;

  state_t            state;
  logic [HOLD_W-1:0] timer;
  logic [CNT_W-1:0]  occ, occ_nxt;
  logic              ovf, ovf_nxt, unf, unf_nxt;
  logic [31:0]       status, rd_mux, total;

  wire unused_wrdata = ^ctl_wrdata;

  assign wr_ctrl = ctl_wr && (ctl_addr == 3'd0);
  assign clr     = wr_ctrl && ctl_wrdata[1];
  assign ev_in   = filt[0] & ~filt_q[0];
  assign ev_out  = filt[1] & ~filt_q[1];

  // Two-flop synchronizers and per-sensor debounce filters.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      sync1  <= '0;
      sync2  <= '0;
      filt   <= '0;
      filt_q <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1  <= {sens_out, sens_in};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != filt[i]) begin
          if (deb_cnt[i] == deb_len) begin
            filt[i]    <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Configuration registers.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      enable   <= 1'b0;
      deb_len  <= DEB_W'(4);
      hold_len <= HOLD_W'(10);
    end else if (ctl_wr) begin
      case (ctl_addr)
        3'd0:    enable   <= ctl_wrdata[0];
        3'd1:    deb_len  <= ctl_wrdata[DEB_W-1:0];
        3'd2:    hold_len <= ctl_wrdata[HOLD_W-1:0];
        default: ;
      endcase
    end
  end

  // Next occupancy and saturation flags; clear beats any event.
  always_comb begin
    occ_nxt = occ;
    ovf_nxt = ovf;
    unf_nxt = unf;
    if (clr) begin
      occ_nxt = '0;
      ovf_nxt = 1'b0;
      unf_nxt = 1'b0;
    end else if (enable) begin
      if (ev_in && !ev_out) begin
        if (occ == OCC_MAX) ovf_nxt = 1'b1;
        else                occ_nxt = occ + CNT_W'(1);
      end else if (ev_out && !ev_in) begin
        if (occ == '0) unf_nxt = 1'b1;
        else           occ_nxt = occ - CNT_W'(1);
      end
    end
  end

  // Section FSM; reacts to the new occupancy on the same edge it changes.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state <= ST_IDLE;
      timer <= '0;
      occ   <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      train <= 1'b0;
      err   <= 1'b0;
    end else begin
      occ <= occ_nxt;
      ovf <= ovf_nxt;
      unf <= unf_nxt;
      err <= ovf_nxt | unf_nxt;
      if (clr || !enable) begin
        state <= ST_IDLE;
        timer <= '0;
        train <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (occ_nxt != '0) begin
              state <= ST_OCC;
              train <= 1'b1;
            end
          end
          ST_OCC: begin
            if (occ_nxt == '0) begin
              if (hold_len == '0) begin
                state <= ST_IDLE;
                train <= 1'b0;
              end else begin
                state <= ST_HOLD;
                timer <= hold_len;
              end
            end
          end
          ST_HOLD: begin
            timer <= timer - HOLD_W'(1);
            if (ev_in) begin
              state <= ST_OCC;
            end else if (timer == HOLD_W'(1)) begin
              state <= ST_IDLE;
              train <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
            train <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef TRAIN_DET_TOTAL_EN
  // Wrap-around count of entry events accepted while enabled.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      total <= '0;
    end else if ((ctl_wr && (ctl_addr == 3'd4)) || clr) begin
      total <= '0;
    end else if (enable && ev_in) begin
      total <= total + 32'd1;
    end
  end
`else
  assign total = '0;
`endif

  // Status word and read mux.
  always_comb begin
    status            = '0;
    status[CNT_W-1:0] = occ;
    status[16]        = train;
    status[17]        = ovf;
    status[18]        = unf;
    status[21:20]     = state;
    rd_mux            = '0;
    case (ctl_addr)
      3'd0:    rd_mux[0]          = enable;
      3'd1:    rd_mux[DEB_W-1:0]  = deb_len;
      3'd2:    rd_mux[HOLD_W-1:0] = hold_len;
      3'd3:    rd_mux             = status;
      3'd4:    rd_mux             = total;
      default: rd_mux             = '0;
    endcase
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk) begin
    if (!clrn)       ctl_rddata <= '0;
    else if (ctl_rd) ctl_rddata <= rd_mux;
  end

endmodule

// File: tb/tb_train_detect.sv
// Directed self-checking bench for train_detect; a second instance with
// CNT_W=2 covers occupancy saturation.
module tb_train_detect;

  logic        clk = 1'b0;
  logic        clrn;
  logic        sens_in, sens_out;
  logic        ctl_wr, ctl_rd;
  logic [2:0]  ctl_addr;
  logic [31:0] ctl_wrdata;
  logic [31:0] rd1, rd2;
  logic        train1, train2, err1, err2;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef TRAIN_DET_TOTAL_EN
  localparam logic [31:0] TOTAL_EXP = 32'd7;
`else
  localparam logic [31:0] TOTAL_EXP = 32'd0;
`endif

  train_detect dut (
    .clk(clk), .clrn(clrn), .sens_in(sens_in), .sens_out(sens_out),
    .ctl_wr(ctl_wr), .ctl_rd(ctl_rd), .ctl_addr(ctl_addr), .ctl_wrdata(ctl_wrdata),
    .ctl_rddata(rd1), .train(train1), .err(err1)
  );

  train_detect #(.CNT_W(2)) dut2 (
    .clk(clk), .clrn(clrn), .sens_in(sens_in), .sens_out(sens_out),
    .ctl_wr(ctl_wr), .ctl_rd(ctl_rd), .ctl_addr(ctl_addr), .ctl_wrdata(ctl_wrdata),
    .ctl_rddata(rd2), .train(train2), .err(err2)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    ctl_wr = 1'b1; ctl_addr = a; ctl_wrdata = d;
    tick();
    ctl_wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a);
    ctl_rd = 1'b1; ctl_addr = a;
    tick();
    ctl_rd = 1'b0;
  endtask

  // which: 0 entry, 1 exit, 2 both
  task automatic pulse(input int which, input int hi, input int lo);
    sens_in  = (which != 1);
    sens_out = (which != 0);
    tick(hi);
    sens_in  = 1'b0;
    sens_out = 1'b0;
    tick(lo);
  endtask

  task automatic test_reset;
    clrn = 1'b0;
    tick(3);
    n_cmp++; if (train1 !== 1'b0) begin n_bad++; $display("FAIL reset_train got %b exp 0", train1); end
    n_cmp++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", err1); end
    n_cmp++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL reset_rddata got %h exp 0", rd1); end
    clrn = 1'b1;
    tick();
    bus_rd(3'd0);
    n_cmp++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl got %h exp 0", rd1); end
    bus_rd(3'd1);
    n_cmp++; if (rd1 !== 32'd4) begin n_bad++; $display("FAIL reset_deblen got %h exp 4", rd1); end
    bus_rd(3'd2);
    n_cmp++; if (rd1 !== 32'd10) begin n_bad++; $display("FAIL reset_holdlen got %h exp a", rd1); end
    bus_rd(3'd3);
    n_cmp++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL reset_status got %h exp 0", rd1); end
  endtask

  task automatic test_basic;
    bus_wr(3'd1, 32'd2);
    bus_wr(3'd2, 32'd5);
    bus_wr(3'd0, 32'd1);
    tick(2);
    sens_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k >= 5) begin
        n_cmp++;
        if (train1 !== (k >= 6)) begin n_bad++; $display("FAIL latency_edge%0d got %b exp %b", k, train1, (k >= 6)); end
      end
    end
    tick(4);
    sens_in = 1'b0;
    tick(10);
    bus_rd(3'd3);
    n_cmp++; if (rd1 !== 32'h0011_0001) begin n_bad++; $display("FAIL basic_occ1 got %h exp 00110001", rd1); end
    sens_out = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 6 || k == 10 || k == 11) begin
        n_cmp++;
        if (train1 !== (k < 11)) begin n_bad++; $display("FAIL hold_edge%0d got %b exp %b", k, train1, (k < 11)); end
      end
    end
    sens_out = 1'b0;
    tick(10);
    bus_rd(3'd3);
    n_cmp++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL basic_idle got %h exp 0", rd1); end
  endtask

  task automatic test_debounce;
    bus_wr(3'd1, 32'd4);
    for (int g = 0; g < 5; g++) pulse(0, 3, 3);
    tick(10);
    bus_rd(3'd3);
    n_cmp++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL deb_glitch got %h exp 0", rd1); end
    n_cmp++; if (train1 !== 1'b0) begin n_bad++; $display("FAIL deb_glitch_train got %b exp 0", train1); end
    pulse(0, 6, 12);
    bus_rd(3'd3);
    n_cmp++; if (rd1 !== 32'h0011_0001) begin n_bad++; $display("FAIL deb_stable got %h exp 00110001", rd1); end
    pulse(1, 10, 20);
    bus_wr(3'd1, 32'd2);
    bus_rd(3'd3);
    n_cmp++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL deb_exit got %h exp 0", rd1); end
  endtask

  task automatic test_hold_cancel;
    logic [31:0] exp_w;
    bit dropped;
    bus_wr(3'd2, 32'd40);
    for (int n = 1; n <= 3; n++) begin
      pulse(0, 10, 10);
      bus_rd(3'd3);
      exp_w = 32'h0011_0000 | 32'(n);
      n_cmp++; if (rd1 !== exp_w) begin n_bad++; $display("FAIL multi_in%0d got %h exp %h", n, rd1, exp_w); end
    end
    for (int n = 2; n >= 0; n--) begin
      pulse(1, 10, 10);
      bus_rd(3'd3);
      exp_w = (n == 0) ? 32'h0021_0000 : (32'h0011_0000 | 32'(n));
      n_cmp++; if (rd1 !== exp_w) begin n_bad++; $display("FAIL multi_out%0d got %h exp %h", n, rd1, exp_w); end
    end
    dropped = 1'b0;
    sens_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) sens_in = 1'b0;
      tick();
      if (train1 !== 1'b1) dropped = 1'b1;
    end
    n_cmp++; if (dropped !== 1'b0) begin n_bad++; $display("FAIL cancel_train_drop got %b exp 0", dropped); end
    bus_rd(3'd3);
    n_cmp++; if (rd1 !== 32'h0011_0001) begin n_bad++; $display("FAIL cancel_state got %h exp 00110001", rd1); end
    bus_wr(3'd0, 32'h3);
    bus_wr(3'd2, 32'd5);
  endtask

  task automatic test_saturation;
    bus_wr(3'd0, 32'h3);
    for (int n = 0; n < 4; n++) pulse(0, 10, 10);
    bus_rd(3'd3);
    n_cmp++; if (rd2 !== 32'h0013_0003) begin n_bad++; $display("FAIL sat_status got %h exp 00130003", rd2); end
    n_cmp++; if (err2 !== 1'b1) begin n_bad++; $display("FAIL sat_err got %b exp 1", err2); end
    n_cmp++; if (rd1 !== 32'h0011_0004) begin n_bad++; $display("FAIL sat_wide_occ got %h exp 00110004", rd1); end
    bus_wr(3'd0, 32'h3);
    n_cmp++; if (err2 !== 1'b0) begin n_bad++; $display("FAIL clear_err got %b exp 0", err2); end
    bus_rd(3'd3);
    n_cmp++; if (rd2 !== 32'h0) begin n_bad++; $display("FAIL clear_status got %h exp 0", rd2); end
    pulse(1, 10, 10);
    bus_rd(3'd3);
    n_cmp++; if (rd2 !== 32'h0004_0000) begin n_bad++; $display("FAIL unf_status got %h exp 00040000", rd2); end
    n_cmp++; if (err2 !== 1'b1) begin n_bad++; $display("FAIL unf_err got %b exp 1", err2); end
  endtask

  task automatic test_simul_enable;
    bus_wr(3'd0, 32'h3);
    pulse(0, 10, 10);
    pulse(2, 10, 10);
    bus_rd(3'd3);
    n_cmp++; if (rd1 !== 32'h0011_0001) begin n_bad++; $display("FAIL simul_occ got %h exp 00110001", rd1); end
    bus_wr(3'd0, 32'h0);
    tick();
    n_cmp++; if (train1 !== 1'b0) begin n_bad++; $display("FAIL disable_train got %b exp 0", train1); end
    bus_rd(3'd3);
    n_cmp++; if (rd1 !== 32'h0000_0001) begin n_bad++; $display("FAIL disable_status got %h exp 00000001", rd1); end
    pulse(0, 10, 10);
    pulse(0, 10, 10);
    bus_rd(3'd3);
    n_cmp++; if (rd1 !== 32'h0000_0001) begin n_bad++; $display("FAIL disabled_events got %h exp 00000001", rd1); end
    bus_wr(3'd0, 32'h3);
  endtask

  task automatic test_hold_zero;
    bus_wr(3'd2, 32'd0);
    pulse(0, 10, 10);
    sens_out = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k >= 5) begin
        n_cmp++;
        if (train1 !== (k < 6)) begin n_bad++; $display("FAIL hold0_edge%0d got %b exp %b", k, train1, (k < 6)); end
      end
    end
    tick(4);
    sens_out = 1'b0;
    tick(10);
    bus_rd(3'd3);
    n_cmp++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL hold0_status got %h exp 0", rd1); end
    bus_wr(3'd2, 32'd5);
  endtask

  task automatic test_total;
    bus_wr(3'd0, 32'h3);
    for (int n = 0; n < 7; n++) pulse(0, 10, 10);
    bus_rd(3'd4);
    n_cmp++; if (rd1 !== TOTAL_EXP) begin n_bad++; $display("FAIL total_count got %h exp %h", rd1, TOTAL_EXP); end
    bus_wr(3'd4, 32'h0);
    bus_rd(3'd4);
    n_cmp++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL total_zero got %h exp 0", rd1); end
    bus_wr(3'd5, 32'hFFFF_FFFF);
    bus_rd(3'd5);
    n_cmp++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL offset5 got %h exp 0", rd1); end
    bus_rd(3'd3);
    n_cmp++; if (rd1 !== 32'h0011_0007) begin n_bad++; $display("FAIL total_occ got %h exp 00110007", rd1); end
  endtask

  task automatic test_reset_mid;
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    n_cmp++; if (train1 !== 1'b0) begin n_bad++; $display("FAIL midreset_train got %b exp 0", train1); end
    n_cmp++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL midreset_rddata got %h exp 0", rd1); end
    bus_rd(3'd3);
    n_cmp++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL midreset_status got %h exp 0", rd1); end
    bus_rd(3'd2);
    n_cmp++; if (rd1 !== 32'd10) begin n_bad++; $display("FAIL midreset_holdlen got %h exp a", rd1); end
  endtask

  initial begin
    clrn = 1'b0; sens_in = 1'b0; sens_out = 1'b0;
    ctl_wr = 1'b0; ctl_rd = 1'b0; ctl_addr = 3'd0; ctl_wrdata = 32'h0;
    test_reset();
    test_basic();
    test_debounce();
    test_hold_cancel();
    test_saturation();
    test_simul_enable();
    test_hold_zero();
    test_total();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/train_detect.md
# train_detect

Upstream track-section detector for the level-crossing semaphore controller. It takes two raw axle sensors, one at the section entry and one at the exit, and synchronizes and debounces them. It keeps an axle occupancy count and drives a clean, held `train` level straight into the semaphore's `train` input. It is configured and monitored over the same `ctl_*` register bus as the semaphore, as a separate bus target.

## Interface
- `DEB_W`, default 8: width of the debounce length register and the debounce counter.
- `CNT_W`, default 8: width of the occupancy counter.
- `HOLD_W`, default 16: width of the hold length register and the hold timer.

- `clk` input 1: sole clock, rising edge.
- `clrn` input 1: reset, synchronous, active-low.
- `sens_in` input 1: raw entry axle sensor, asynchronous, bouncy, high while an axle is present.
- `sens_out` input 1: raw exit axle sensor, same characteristics as `sens_in`.
- `ctl_wr` input 1: register write strobe, one cycle.
- `ctl_rd` input 1: register read strobe, one cycle.
- `ctl_addr` input 3: register offset.
- `ctl_wrdata` input 32: write data.
- `ctl_rddata` output 32: registered read data.
- `train` output 1: section occupied or in hold; feeds the semaphore.
- `err` output 1: sticky OR of the overflow and underflow flags.

## Operation
- **Register map:**
  - 0 CTRL (R/W): bit0 `enable`; bit1 `clear`, write-only and self-clearing. Writing 1 to `clear` zeroes `occ`, `ovf`, `unf` and the total counter, and forces IDLE.
  - 1 DEB_LEN (R/W): [DEB_W-1:0].
  - 2 HOLD_LEN (R/W): [HOLD_W-1:0].
  - 3 STATUS (RO): [CNT_W-1:0] `occ`; bit16 `train`; bit17 `ovf`; bit18 `unf`; [21:20] state (0 IDLE, 1 OCC, 2 HOLD).
  - 4 TOTAL (see Configuration).
  - Offsets 5–7 read 0; writes to them are ignored.
- **Sensor path:**
  - Each sensor passes through a 2-flop synchronizer.
  - Debounce: per-sensor counter. While the synced value differs from the filtered value, the counter increments each cycle. On the cycle where the values differ and counter==DEB_LEN, filtered <= synced and the counter resets to 0. Any cycle where the values match resets the counter.
  - An axle event is a rising edge of a filtered sensor.
- **Occupancy:**
  - Entry event without exit event: occ+1. Exit event without entry event: occ−1. Both in the same cycle: occ unchanged.
  - occ at max with an entry event: occ holds, `ovf` sets. occ at 0 with an exit event: occ holds, `unf` sets.
- **FSM:**
  - IDLE (train=0): occ becomes nonzero → OCC.
  - OCC (train=1): occ becomes 0 → HOLD with the hold timer loaded to HOLD_LEN; if HOLD_LEN==0, go directly to IDLE.
  - HOLD (train=1): the timer decrements each cycle. Timer==1 → IDLE. An entry event → OCC, cancelling the hold.
  - `enable`=0: FSM held in IDLE, events ignored, occ frozen. The synchronizers and debouncers keep running.
- **Bus writes** take effect on the edge where `ctl_wr`=1.
- **Bus reads:** `ctl_rddata` loads on the edge where `ctl_rd`=1 and holds its value otherwise.

## Timing
- **Reset values:**
  - Outputs: `train`=0, `err`=0, `ctl_rddata`=0.
  - Registers: enable=0, DEB_LEN=4, HOLD_LEN=10.
  - State: occ=0, state IDLE, filtered sensors=0, counters=0.
- **Raw-to-train latency:** a raw sensor that rises and stays high produces its event and a `train` rise DEB_LEN+4 edges later: 2 synchronizer edges, DEB_LEN+1 debounce edges, 1 edge to update occ/state. `train` is registered and changes on the same edge as the state.
- **Hold:** `train` falls exactly HOLD_LEN edges after the edge on which occ became 0. With HOLD_LEN=0, it falls on that same edge.
- **Clear/enable priority:** `clear` and an axle event in the same cycle → clear wins. Disabling while in OCC or HOLD → IDLE and `train`=0 on the next edge.
- **Reset mid-operation:** all state returns to reset values on the first edge with `clrn`=0.
- **Register writes:** a DEB_LEN write mid-debounce applies on the next compare. A HOLD_LEN write during HOLD does not affect the running timer.

## Configuration
- Macro `TRAIN_DET_TOTAL_EN`.
- **Defined:**
  - Offset 4 returns a 32-bit wrap-around count of entry events accepted while enabled.
  - Any write to offset 4 zeroes it.
  - CTRL `clear` also zeroes it.
- **Undefined:** no counter is built; offset 4 reads 0 and writes are ignored.

## Test plan
- **Basic occupancy:** reset, DEB_LEN=2, HOLD_LEN=5, enable. Pulse `sens_in` high 10 cycles → `train` rises 6 edges after the raw rise, STATUS occ=1. Pulse `sens_out` → occ=0, `train` falls 5 edges later.
- **Debounce:** DEB_LEN=4, toggle `sens_in` with 3-cycle glitches ×5 → no event, occ=0, `train`=0. A following 6-cycle-stable high → one event, occ=1.
- **Hold cancel and multi-axle:** 3 entry pulses then 3 exit pulses → occ steps 1,2,3,2,1,0. A further entry pulse during HOLD → state OCC, `train` never drops.
- **Saturation:** CNT_W=2; 4 entry pulses → occ=3, `ovf`=1, `err`=1. CTRL write 0x3 → occ=0, `err`=0, state IDLE. An exit pulse at occ=0 → `unf`=1, occ=0.
- **Simultaneous events and enable:** entry and exit events on the same edge at occ=1 → occ stays 1. Write CTRL=0 while in OCC → `train`=0 next edge and STATUS state=0. Entry pulses while disabled → occ unchanged.
- **Total counter (`TRAIN_DET_TOTAL_EN` defined):** 7 entry pulses → offset 4 reads 7. Write offset 4 → reads 0. Without the macro, offset 4 always reads 0.
